// File: rtl/shift_pkg.sv
// Shared shift-scheduler constants: function codes, default widths and requester ids.
package shift_pkg;
  localparam int DATA_W_DEF  = 32;
  localparam int SHAMT_W_DEF = 5;

  localparam logic [1:0] FUN_SLL = 2'b00;
  localparam logic [1:0] FUN_SRL = 2'b01;
  localparam logic [1:0] FUN_SRA = 2'b11;

  localparam logic REQ_ID0 = 1'b0;
  localparam logic REQ_ID1 = 1'b1;
endpackage

// File: rtl/shift_sched_if.sv
// Two-requester shift request / response bundle; master = requesters+sink, slave = scheduler.
interface shift_sched_if
  import shift_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF
);
  logic               req0_valid;
  logic               req0_ready;
  logic [DATA_W-1:0]  req0_data;
  logic [SHAMT_W-1:0] req0_shamt;
  logic [1:0]         req0_fun;
  logic               req1_valid;
  logic               req1_ready;
  logic [DATA_W-1:0]  req1_data;
  logic [SHAMT_W-1:0] req1_shamt;
  logic [1:0]         req1_fun;
  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_id;
  logic [DATA_W-1:0]  rsp_data;

  modport master (
    output req0_valid, req0_data, req0_shamt, req0_fun,
    output req1_valid, req1_data, req1_shamt, req1_fun,
    output rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req0_valid, req0_data, req0_shamt, req0_fun,
    input  req1_valid, req1_data, req1_shamt, req1_fun,
    input  rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/shift_core.sv
// shift_core: stateless log-stage barrel shifter (SLL/SRL/SRA), purely combinational.
module shift_core
  import shift_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF
) (
  input  logic [DATA_W-1:0]  data_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic [1:0]         fun_i,
  output logic [DATA_W-1:0]  res_o
);
  localparam logic [DATA_W-1:0] ONES = '1;

  logic              left;
  logic              fill;
  logic [DATA_W-1:0] acc;

  assign left = !fun_i[0];
  assign fill = (fun_i == FUN_SRA) && data_i[DATA_W-1];

  // One conditional stage per shamt bit, largest first (16/8/4/2/1 for 32 bits).
  always_comb begin
    acc = data_i;
    for (int k = SHAMT_W - 1; k >= 0; k--) begin
      if (shamt_i[k]) begin
        if (left) begin
          acc = acc << (1 << k);
        end else begin
          acc = (acc >> (1 << k)) | (fill ? ~(ONES >> (1 << k)) : '0);
        end
      end
    end
  end

  assign res_o = acc;
endmodule

// File: rtl/shift_sched.sv
// shift_sched: two-requester arbitrated shifter, S1 (request) -> S2 (result), 2-cycle latency.
// rsp_ready low stalls S2 then S1, dropping both req readys. SHIFT_SCHED_RR_EN selects round-robin ties.
module shift_sched
  import shift_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  shift_sched_if.slave bus
);
  typedef struct packed {
    logic               id;
    logic [1:0]         fun;
    logic [SHAMT_W-1:0] shamt;
    logic [DATA_W-1:0]  data;
  } s1_t;

  s1_t               s1_q, s1_d, req_sel;
  logic              s1_vld_q, s1_vld_d;
  logic              s2_vld_q, s2_vld_d;
  logic              s2_id_q, s2_id_d;
  logic [DATA_W-1:0] s2_dat_q, s2_dat_d;
  logic [DATA_W-1:0] shift_res;
  logic              advance, accept, grant, take;

  assign advance = !s2_vld_q || bus.rsp_ready;
  assign accept  = !s1_vld_q || advance;

`ifdef SHIFT_SCHED_RR_EN
  logic last_q, last_d;

  // On a tie the port that did not win last time is served.
  assign grant  = (bus.req0_valid && bus.req1_valid) ? ~last_q : bus.req1_valid;
  assign last_d = take ? grant : last_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= REQ_ID1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  assign grant = !bus.req0_valid && bus.req1_valid;
`endif

  assign bus.req0_ready = reset && accept && (grant == REQ_ID0);
  assign bus.req1_ready = reset && accept && (grant == REQ_ID1);
  assign take           = accept && (grant ? bus.req1_valid : bus.req0_valid);

  always_comb begin
    req_sel = '{id: REQ_ID0, fun: bus.req0_fun, shamt: bus.req0_shamt, data: bus.req0_data};
    if (grant) begin
      req_sel = '{id: REQ_ID1, fun: bus.req1_fun, shamt: bus.req1_shamt, data: bus.req1_data};
    end
  end

  shift_core #(
    .DATA_W  (DATA_W),
    .SHAMT_W (SHAMT_W)
  ) u_core (
    .data_i  (s1_q.data),
    .shamt_i (s1_q.shamt),
    .fun_i   (s1_q.fun),
    .res_o   (shift_res)
  );

  always_comb begin
    s1_d     = take ? req_sel : s1_q;
    s1_vld_d = take ? 1'b1 : (advance ? 1'b0 : s1_vld_q);
    s2_vld_d = advance ? s1_vld_q : s2_vld_q;
    s2_id_d  = (advance && s1_vld_q) ? s1_q.id : s2_id_q;
    s2_dat_d = (advance && s1_vld_q) ? shift_res : s2_dat_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q     <= '0;
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      s2_id_q  <= REQ_ID0;
      s2_dat_q <= '0;
    end else begin
      s1_q     <= s1_d;
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
      s2_id_q  <= s2_id_d;
      s2_dat_q <= s2_dat_d;
    end
  end

  assign bus.rsp_valid = s2_vld_q;
  assign bus.rsp_id    = s2_id_q;
  assign bus.rsp_data  = s2_dat_q;
endmodule

// File: tb/tb_shift_sched.sv
// Bench for shift_sched: queue-based reference model checked every cycle plus directed scenarios.
module tb_shift_sched;
  logic clk;
  logic reset;
  int   cyc = 0;
  int   n_tot = 0;
  int   n_pass = 0;

  shift_sched_if #(.DATA_W(32), .SHAMT_W(5)) bus ();

  shift_sched #(.DATA_W(32), .SHAMT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        id;
    logic [31:0] dat;
    int          acc;
  } exp_t;

  exp_t q[$];
  logic last_w = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] mshift(input logic [31:0] d, input logic [4:0] s, input logic [1:0] f);
    int sh;
    sh = int'(s) % 32;
    if (!f[0]) return d << sh;
    else if (!f[1]) return d >> sh;
    else return $signed(d) >>> sh;
  endfunction

  // Reference model: in-flight queue in acceptance order, head visible two cycles after acceptance.
  always @(negedge clk) begin
    logic cap, g, tie, exp_rv;
    exp_t e;
    if (!reset) begin
      q.delete();
      last_w = 1'b1;
      chk("rst_ready0", bus.req0_ready, 0);
      chk("rst_ready1", bus.req1_ready, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rsp_id", bus.rsp_id, 0);
      chk("rst_rsp_data", bus.rsp_data, 0);
    end else begin
      cap = (q.size() < 2) || bus.rsp_ready;
`ifdef SHIFT_SCHED_RR_EN
      tie = ~last_w;
`else
      tie = 1'b0;
`endif
      g = (bus.req0_valid && bus.req1_valid) ? tie : bus.req1_valid;
      chk("ready0", bus.req0_ready, cap && !g);
      chk("ready1", bus.req1_ready, cap && g);
      exp_rv = 1'b0;
      if (q.size() > 0) exp_rv = (cyc >= q[0].acc + 2);
      chk("rsp_valid", bus.rsp_valid, exp_rv);
      if (exp_rv && bus.rsp_valid) begin
        chk("rsp_id", bus.rsp_id, q[0].id);
        chk("rsp_data", bus.rsp_data, q[0].dat);
      end
      if (bus.rsp_valid && bus.rsp_ready && q.size() > 0) void'(q.pop_front());
      if (bus.req0_valid && bus.req0_ready) begin
        e.id = 1'b0; e.dat = mshift(bus.req0_data, bus.req0_shamt, bus.req0_fun); e.acc = cyc;
        q.push_back(e);
        last_w = 1'b0;
      end else if (bus.req1_valid && bus.req1_ready) begin
        e.id = 1'b1; e.dat = mshift(bus.req1_data, bus.req1_shamt, bus.req1_fun); e.acc = cyc;
        q.push_back(e);
        last_w = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int port, input logic [31:0] d, input logic [4:0] s, input logic [1:0] f);
    if (port == 0) begin
      bus.req0_valid = 1'b1; bus.req0_data = d; bus.req0_shamt = s; bus.req0_fun = f;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_data = d; bus.req1_shamt = s; bus.req1_fun = f;
    end
  endtask

  task automatic idle();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  logic [31:0] vd[8];
  logic [4:0]  vs[8];
  logic [1:0]  vf[8];
  logic [31:0] hold_d[3];
  logic        exp_id[6];
  logic        saw1;
  logic        hs;
  int          idx;

  initial begin
    reset = 1'b1;
    idle();
    bus.req0_data = '0; bus.req0_shamt = '0; bus.req0_fun = '0;
    bus.req1_data = '0; bus.req1_shamt = '0; bus.req1_fun = '0;
    bus.rsp_ready = 1'b1;
    #1 reset = 1'b0;

    chk("model_sra", mshift(32'h8000_0000, 5'd4, 2'b11), 32'hF800_0000);
    chk("model_sll", mshift(32'h0000_0001, 5'd31, 2'b00), 32'h8000_0000);
    chk("model_srl", mshift(32'h8000_0000, 5'd31, 2'b01), 32'h0000_0001);
    chk("model_sh0", mshift(32'hDEAD_BEEF, 5'd0, 2'b11), 32'hDEAD_BEEF);

    repeat (2) @(negedge clk);
    tick();
    reset = 1'b1;

    // Single SRA request: visible exactly two cycles after being presented.
    drive(0, 32'h8000_0000, 5'd4, 2'b11);
    tick(); idle();
    @(negedge clk); chk("lat_early", bus.rsp_valid, 0);
    tick();
    @(negedge clk);
    chk("sra_valid", bus.rsp_valid, 1);
    chk("sra_id", bus.rsp_id, 0);
    chk("sra_data", bus.rsp_data, 32'hF800_0000);

    tick(); drive(1, 32'h0000_0001, 5'd31, 2'b00);
    tick(); drive(1, 32'h8000_0000, 5'd31, 2'b01);
    tick(); idle();
    @(negedge clk); chk("sll31_id", bus.rsp_id, 1); chk("sll31_data", bus.rsp_data, 32'h8000_0000);
    tick();
    @(negedge clk); chk("srl31_id", bus.rsp_id, 1); chk("srl31_data", bus.rsp_data, 32'h0000_0001);

    // Back-to-back mixed vectors through alternating ports at full rate.
    vd = '{32'h1234_5678, 32'hF000_000F, 32'h7FFF_FFFF, 32'h8000_0001,
           32'hA5A5_A5A5, 32'h0000_FFFF, 32'hC000_0000, 32'h0F0F_0F0F};
    vs = '{5'd0, 5'd8, 5'd31, 5'd1, 5'd16, 5'd3, 5'd30, 5'd0};
    vf = '{2'b11, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b11, 2'b01};
    for (int i = 0; i < 8; i++) begin
      tick(); idle(); drive(i % 2, vd[i], vs[i], vf[i]);
    end
    tick(); idle();
    repeat (3) tick();

    // Both requesters valid for six cycles.
`ifdef SHIFT_SCHED_RR_EN
    exp_id = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_id = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    saw1 = 1'b0;
    drive(0, 32'h0000_00AA, 5'd1, 2'b00);
    drive(1, 32'h0000_0055, 5'd1, 2'b00);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i >= 2) chk("tie_id", bus.rsp_id, exp_id[i-2]);
      if (bus.req1_ready) saw1 = 1'b1;
      tick();
      if (i == 5) idle();
    end
`ifdef SHIFT_SCHED_RR_EN
    chk("tie_r1_seen", saw1, 1);
`else
    chk("tie_r1_seen", saw1, 0);
`endif
    repeat (3) tick();

    // Three requests against a sink stalled for five cycles.
    hold_d = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    idx = 0;
    for (int k = 0; k < 10; k++) begin
      idle();
      if (idx < 3) drive(0, hold_d[idx], 5'd0, 2'b00);
      bus.rsp_ready = (k >= 5);
      @(negedge clk);
      hs = bus.req0_valid && bus.req0_ready;
      if (k >= 2 && k <= 4) begin
        chk("stall_ready0", bus.req0_ready, 0);
        chk("stall_ready1", bus.req1_ready, 0);
        chk("stall_hold", bus.rsp_data, 32'h1111_1111);
      end
      if (k >= 5 && k <= 7) chk("stall_order", bus.rsp_data, hold_d[k-5]);
      tick();
      if (hs) idx++;
    end
    chk("stall_all_sent", idx, 3);
    idle();
    repeat (3) tick();

    // Reset with both stages full, then a fresh request.
    bus.rsp_ready = 1'b0;
    drive(0, 32'hAAAA_0001, 5'd0, 2'b00);
    tick(); drive(0, 32'hBBBB_0002, 5'd0, 2'b00);
    tick(); idle();
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_valid", bus.rsp_valid, 0);
    chk("mid_rst_ready0", bus.req0_ready, 0);
    repeat (2) tick();
    reset = 1'b1;
    bus.rsp_ready = 1'b1;
    drive(0, 32'h0000_F00F, 5'd4, 2'b01);
    tick(); idle();
    @(negedge clk); chk("post_rst_nostale", bus.rsp_valid, 0);
    tick();
    @(negedge clk);
    chk("post_rst_valid", bus.rsp_valid, 1);
    chk("post_rst_data", bus.rsp_data, 32'h0000_0F00);
    repeat (3) tick();
    chk("drained", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/shift_sched.md
SHIFT_SCHED -- requirements
Module: shift_sched

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width.
REQ-002 SHALL have parameter SHAMT_W, default 5, shift-amount width; SHALL equal log2(DATA_W).
REQ-003 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-004 SHALL have port reset, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have ports req0_valid in 1, req0_ready out 1, req0_data in DATA_W, req0_shamt in SHAMT_W, req0_fun in 2 (requester 0, pipeline ALU).
REQ-006 SHALL have ports req1_valid in 1, req1_ready out 1, req1_data in DATA_W, req1_shamt in SHAMT_W, req1_fun in 2 (requester 1, auxiliary unit).
REQ-007 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_id out 1 (originating requester), rsp_data out DATA_W.

Function
REQ-008 fun encoding SHALL be: bit0=0 -> logical left; bit0=1,bit1=0 -> logical right; bit0=1,bit1=1 -> arithmetic right (sign fill from data[DATA_W-1]).
REQ-009 Shift amount SHALL be taken modulo DATA_W (shamt bits only); shamt=0 returns data unchanged.
REQ-010 Datapath SHALL be two register stages: S1 captures granted request; S2 captures shifted result; result visible on rsp_* exactly 2 cycles after the accepting edge when rsp_ready held high.
REQ-011 advance = !s2_valid || rsp_ready; S1->S2 transfer SHALL occur only when advance.
REQ-012 accept = !s1_valid || advance; a request SHALL be accepted only when accept and its valid are high.
REQ-013 At most one of req0_ready/req1_ready SHALL be high per cycle; readyX = accept && grant==X, grant combinational from current valids.
REQ-014 Single valid requester SHALL be granted regardless of arbitration state.
REQ-015 Both valid: arbitration per REQ-021/REQ-022.
REQ-016 rsp_valid high and rsp_ready low SHALL hold rsp_valid, rsp_id, rsp_data stable until handshake; no result dropped or duplicated.
REQ-017 Full throughput: with rsp_ready=1 and continuous requests, one accept and one response per cycle.
REQ-018 Responses SHALL emerge in acceptance order.

Reset
REQ-019 reset low SHALL asynchronously clear s1_valid, s2_valid, rsp_valid=0, rsp_id=0, rsp_data=0, last-grant pointer=1 (so port 0 wins first tie); req*_ready combinationally 0 while reset low.
REQ-020 Reset asserted mid-operation SHALL discard all in-flight requests; first accept allowed on first rising edge after reset release.

Configuration
REQ-021 Macro SHIFT_SCHED_RR_EN defined: round-robin; on tie, grant port != last-grant pointer; pointer updates only on an accepted grant.
REQ-022 Macro undefined: fixed priority, port 0 always wins ties; pointer logic absent.

Structure
REQ-023 Shared package shift_pkg SHALL hold fun encodings (FUN_SLL, FUN_SRL, FUN_SRA), DATA_W/SHAMT_W defaults, requester-id constants.
REQ-024 Sub-module shift_core SHALL implement the combinational log-stage barrel shifter (16/8/4/2/1 stages for DATA_W=32), instantiated between S1 and S2.
REQ-025 Arbitration and handshake SHALL live in shift_sched only; shift_core SHALL be stateless.

Verification
REQ-026 req0: data=0x80000000, shamt=4, fun=SRA, rsp_ready=1 -> 2 cycles later rsp_valid=1, rsp_id=0, rsp_data=0xF8000000.
REQ-027 req1: data=0x00000001, shamt=31, fun=SLL -> rsp_data=0x80000000, rsp_id=1; then data=0x80000000, shamt=31, fun=SRL -> 0x00000001.
REQ-028 Both valid 6 cycles, rsp_ready=1: RR_EN -> rsp_id sequence 0,1,0,1,0,1; without macro -> 0,0,0,0,0,0 and req1_ready never high.
REQ-029 Three back-to-back accepts, rsp_ready=0 for 5 cycles: both readys drop after S1 and S2 fill, rsp_data held constant; rsp_ready=1 -> three responses in order, none lost.
REQ-030 reset low with S1 and S2 full -> same cycle rsp_valid=0; after release, no stale response; new request returns after 2 cycles.
